alu_pipe: RTL and testbench

- Parametrised, registered successor to the datapath ALU.
- Executes the existing 3-bit ALU op map at any width W: ADD 000, SUB 001, SHR 010, SHL 011, AND 100, OR 101, XOR 110, PASS 111.
- Adds status flags, a valid/ready handshake on both sides, and an optional serial (one bit per cycle) shifter for area-constrained builds.
- Sits between operand fetch and writeback in the processor datapath.

---
 rtl/alu_pipe.sv | 160 ++++++++++++++++
 tb/tb_alu_pipe.sv | 191 +++++++++++++++++++
 2 files changed

// File: rtl/alu_pipe.sv
// rtl/alu_pipe.sv - registered W-bit ALU with flags, valid/ready handshake and optional serial shifter
module alu_pipe #(
  parameter int W            = 8,
  parameter int SERIAL_SHIFT = 0
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [2:0]   op,
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] result,
  output logic         zero,
  output logic         negative,
  output logic         carry,
  output logic         overflow
);

  localparam int SHW = $clog2(W);

  localparam logic [2:0] OP_ADD  = 3'b000;
  localparam logic [2:0] OP_SUB  = 3'b001;
  localparam logic [2:0] OP_SHR  = 3'b010;
  localparam logic [2:0] OP_SHL  = 3'b011;
  localparam logic [2:0] OP_AND  = 3'b100;
  localparam logic [2:0] OP_OR   = 3'b101;
  localparam logic [2:0] OP_XOR  = 3'b110;
  localparam logic [2:0] OP_PASS = 3'b111;

  typedef enum logic {IDLE, SHIFT} state_t;

  state_t         r_state;
  state_t         w_state_next;
  logic           r_out_valid;
  logic [W-1:0]   r_result;
  logic           r_zero;
  logic           r_negative;
  logic           r_carry;
  logic           r_overflow;
  logic [W-1:0]   r_sh_val;
  logic [SHW-1:0] r_sh_cnt;
  logic           r_sh_right;

  logic [SHW-1:0] w_amt;
  logic [W:0]     w_sum;
  logic [W:0]     w_diff;
  logic [W-1:0]   w_res;
  logic           w_c;
  logic           w_v;
  logic           w_accept;
  logic           w_go_serial;
  logic           w_last;
  logic [W-1:0]   w_step_val;
  logic           w_step_bit;

  assign w_amt       = b[SHW-1:0];
  assign w_sum       = {1'b0, a} + {1'b0, b};
  assign w_diff      = {1'b0, a} + {1'b0, ~b} + {{W{1'b0}}, 1'b1};
  assign in_ready    = (r_state == IDLE) && (!r_out_valid || out_ready);
  assign w_accept    = in_valid && in_ready;
  // A zero-amount shift takes the single-cycle path even in serial builds
  assign w_go_serial = (SERIAL_SHIFT != 0) && (op[2:1] == 2'b01) && (w_amt != '0);
  assign w_last      = (r_sh_cnt == SHW'(1));
  assign w_step_val  = r_sh_right ? (r_sh_val >> 1) : (r_sh_val << 1);
  assign w_step_bit  = r_sh_right ? r_sh_val[0] : r_sh_val[W-1];

  assign out_valid = r_out_valid;
  assign result    = r_result;
  assign zero      = r_zero;
  assign negative  = r_negative;
  assign carry     = r_carry;
  assign overflow  = r_overflow;

  // Single-cycle result and carry/overflow for the presented op; the extra
  // guard bit on each shift captures the last bit shifted out (0 for amount 0)
  always_comb begin
    w_res = '0;
    w_c   = 1'b0;
    w_v   = 1'b0;
    case (op)
      OP_ADD: begin
        {w_c, w_res} = w_sum;
        w_v = (a[W-1] == b[W-1]) && (w_sum[W-1] != a[W-1]);
      end
      OP_SUB: begin
        {w_c, w_res} = w_diff;
        w_v = (a[W-1] != b[W-1]) && (w_diff[W-1] != a[W-1]);
      end
      OP_SHR:  {w_res, w_c} = {a, 1'b0} >> w_amt;
      OP_SHL:  {w_c, w_res} = {1'b0, a} << w_amt;
      OP_AND:  w_res = a & b;
      OP_OR:   w_res = a | b;
      OP_XOR:  w_res = a ^ b;
      OP_PASS: w_res = b;
      default: w_res = '0;
    endcase
  end

  // FSM state register
  always_ff @(posedge clk) begin
    if (reset) r_state <= IDLE;
    else       r_state <= w_state_next;
  end

  // FSM next state: leave IDLE only for a non-zero serial shift, return on its last bit
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      IDLE:    if (w_accept && w_go_serial) w_state_next = SHIFT;
      SHIFT:   if (w_last) w_state_next = IDLE;
      default: w_state_next = IDLE;
    endcase
  end

  // Datapath: capture at accept, step the serial shifter, hold output under backpressure
  always_ff @(posedge clk) begin
    if (reset) begin
      r_out_valid <= 1'b0;
      r_result    <= '0;
      r_zero      <= 1'b0;
      r_negative  <= 1'b0;
      r_carry     <= 1'b0;
      r_overflow  <= 1'b0;
      r_sh_val    <= '0;
      r_sh_cnt    <= '0;
      r_sh_right  <= 1'b0;
    end else if (r_state == SHIFT) begin
      r_sh_val <= w_step_val;
      r_sh_cnt <= r_sh_cnt - SHW'(1);
      if (w_last) begin
        r_result    <= w_step_val;
        r_carry     <= w_step_bit;
        r_zero      <= (w_step_val == '0);
        r_negative  <= w_step_val[W-1];
        r_overflow  <= 1'b0;
        r_out_valid <= 1'b1;
      end
    end else if (w_accept) begin
      if (w_go_serial) begin
        r_sh_val    <= a;
        r_sh_cnt    <= w_amt;
        r_sh_right  <= (op == OP_SHR);
        r_out_valid <= 1'b0;
      end else begin
        r_result    <= w_res;
        r_carry     <= w_c;
        r_overflow  <= w_v;
        r_zero      <= (w_res == '0);
        r_negative  <= w_res[W-1];
        r_out_valid <= 1'b1;
      end
    end else if (out_ready) begin
      r_out_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_alu_pipe.sv
// tb/tb_alu_pipe.sv - directed self-checking bench for alu_pipe (barrel instance 0, serial instance 1)
module tb_alu_pipe;

  logic       clk = 1'b0;
  logic       reset;
  logic       in_valid  [2];
  logic       in_ready  [2];
  logic [2:0] op        [2];
  logic [7:0] a         [2];
  logic [7:0] b         [2];
  logic       out_valid [2];
  logic       out_ready [2];
  logic [7:0] result    [2];
  logic       zero      [2];
  logic       negative  [2];
  logic       carry     [2];
  logic       overflow  [2];

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  alu_pipe #(.W(8), .SERIAL_SHIFT(0)) u_bar (
    .clk(clk), .reset(reset), .in_valid(in_valid[0]), .in_ready(in_ready[0]),
    .op(op[0]), .a(a[0]), .b(b[0]), .out_valid(out_valid[0]), .out_ready(out_ready[0]),
    .result(result[0]), .zero(zero[0]), .negative(negative[0]), .carry(carry[0]),
    .overflow(overflow[0])
  );

  alu_pipe #(.W(8), .SERIAL_SHIFT(1)) u_ser (
    .clk(clk), .reset(reset), .in_valid(in_valid[1]), .in_ready(in_ready[1]),
    .op(op[1]), .a(a[1]), .b(b[1]), .out_valid(out_valid[1]), .out_ready(out_ready[1]),
    .result(result[1]), .zero(zero[1]), .negative(negative[1]), .carry(carry[1]),
    .overflow(overflow[1])
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic expect_out(input int d, input string tag, input logic [7:0] res,
                            input logic z, input logic n, input logic c, input logic v);
    check({tag, ".valid"}, 32'(out_valid[d]), 32'd1);
    check({tag, ".result"}, 32'(result[d]), 32'(res));
    check({tag, ".zero"}, 32'(zero[d]), 32'(z));
    check({tag, ".neg"}, 32'(negative[d]), 32'(n));
    check({tag, ".carry"}, 32'(carry[d]), 32'(c));
    check({tag, ".ovf"}, 32'(overflow[d]), 32'(v));
  endtask

  // Present one operation, wait (bounded) for acceptance, return just after the accept edge
  task automatic send(input int d, input logic [2:0] o, input logic [7:0] va, input logic [7:0] vb);
    int k;
    k = 0;
    in_valid[d] = 1'b1;
    op[d] = o;
    a[d]  = va;
    b[d]  = vb;
    while (!in_ready[d] && k < 50) begin
      tick();
      k++;
    end
    check("send_timeout", 32'(k < 50), 32'd1);
    tick();
    in_valid[d] = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1;
    for (int d = 0; d < 2; d++) begin
      in_valid[d] = 1'b0; op[d] = 3'b000; a[d] = 8'h00; b[d] = 8'h00; out_ready[d] = 1'b1;
    end
    tick();
    reset = 1'b0;

    // Reset held two cycles while traffic is offered
    for (int d = 0; d < 2; d++) begin
      in_valid[d] = 1'b1; op[d] = 3'b000; a[d] = 8'h12; b[d] = 8'h34;
    end
    tick();
    reset = 1'b1;
    tick();
    tick();
    for (int d = 0; d < 2; d++) in_valid[d] = 1'b0;
    reset = 1'b0;
    for (int d = 0; d < 2; d++) begin
      check("rst.valid", 32'(out_valid[d]), 32'd0);
      check("rst.result", 32'(result[d]), 32'h00);
      check("rst.flags", {28'd0, zero[d], negative[d], carry[d], overflow[d]}, 32'd0);
      check("rst.in_ready", 32'(in_ready[d]), 32'd1);
    end

    // ADD back-to-back on both instances
    for (int d = 0; d < 2; d++) begin
      in_valid[d] = 1'b1; op[d] = 3'b000; a[d] = 8'h7F; b[d] = 8'h01;
      tick();
      expect_out(d, "add7f", 8'h80, 1'b0, 1'b1, 1'b0, 1'b1);
      check("add.in_ready", 32'(in_ready[d]), 32'd1);
      a[d] = 8'hFF; b[d] = 8'h01;
      tick();
      expect_out(d, "addff", 8'h00, 1'b1, 1'b0, 1'b1, 1'b0);
      in_valid[d] = 1'b0;
      tick();
      check("add.drain", 32'(out_valid[d]), 32'd0);
    end

    // SUB borrow and signed overflow
    send(0, 3'b001, 8'h05, 8'h07);
    expect_out(0, "sub05", 8'hFE, 1'b0, 1'b1, 1'b0, 1'b0);
    send(0, 3'b001, 8'h80, 8'h01);
    expect_out(0, "sub80", 8'h7F, 1'b0, 1'b0, 1'b1, 1'b1);
    tick();

    // Serial SHL by 3: in_ready low for the three shift cycles
    send(1, 3'b011, 8'h81, 8'h03);
    for (int i = 0; i < 3; i++) begin
      check("ser.shl.in_ready", 32'(in_ready[1]), 32'd0);
      check("ser.shl.valid_lo", 32'(out_valid[1]), 32'd0);
      tick();
    end
    expect_out(1, "ser.shl", 8'h08, 1'b0, 1'b0, 1'b0, 1'b0);
    send(1, 3'b010, 8'h81, 8'h00);
    expect_out(1, "ser.shr0", 8'h81, 1'b0, 1'b1, 1'b0, 1'b0);
    // Upper bits of b ignored: amount 9 -> 1
    send(1, 3'b010, 8'h81, 8'h09);
    tick();
    expect_out(1, "ser.shr1", 8'h40, 1'b0, 1'b0, 1'b1, 1'b0);
    tick();

    // Barrel: same shifts, latency 1
    send(0, 3'b011, 8'h81, 8'h03);
    expect_out(0, "bar.shl", 8'h08, 1'b0, 1'b0, 1'b0, 1'b0);
    send(0, 3'b010, 8'h81, 8'h00);
    expect_out(0, "bar.shr0", 8'h81, 1'b0, 1'b1, 1'b0, 1'b0);
    send(0, 3'b010, 8'h81, 8'h09);
    expect_out(0, "bar.shr1", 8'h40, 1'b0, 1'b0, 1'b1, 1'b0);
    tick();

    // Backpressure: XOR result held for 4 cycles, pending PASS not taken
    out_ready[0] = 1'b0;
    send(0, 3'b110, 8'hF0, 8'hFF);
    in_valid[0] = 1'b1; op[0] = 3'b111; a[0] = 8'h00; b[0] = 8'h33;
    for (int i = 0; i < 4; i++) begin
      expect_out(0, "bp.hold", 8'h0F, 1'b0, 1'b0, 1'b0, 1'b0);
      check("bp.in_ready", 32'(in_ready[0]), 32'd0);
      tick();
    end
    out_ready[0] = 1'b1;
    #1;
    check("bp.resume_ready", 32'(in_ready[0]), 32'd1);
    tick();
    in_valid[0] = 1'b0;
    expect_out(0, "bp.pass", 8'h33, 1'b0, 1'b0, 1'b0, 1'b0);
    tick();

    // Mid-shift reset on serial instance abandons the shift
    send(1, 3'b011, 8'h01, 8'h07);
    tick();
    tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    for (int i = 0; i < 8; i++) begin
      check("midrst.no_valid", 32'(out_valid[1]), 32'd0);
      tick();
    end
    send(1, 3'b111, 8'h00, 8'h5A);
    expect_out(1, "midrst.pass", 8'h5A, 1'b0, 1'b0, 1'b0, 1'b0);
    tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
